// File: rtl/common_lib_rdy_vld_to_pulse.sv
// Purpose: replays rdy/vld commands as in_cnt single-cycle pulses, PULSE_GAP idle cycles apart.
// Latency: accept -> first out_pulse is 1 cycle (2 with COMMON_LIB_RDY_VLD_TO_PULSE_IN_PIPE_EN).
// Backpressure: in_rdy drops while pulses remain; it rises early so back-to-back commands keep uniform spacing.
// Optional build macro: COMMON_LIB_RDY_VLD_TO_PULSE_IN_PIPE_EN adds a registered input stage and a flopped in_rdy.

module common_lib_rdy_vld_to_pulse #(
   parameter int CNT_W     = 8,
   parameter int PULSE_GAP = 0
) (
   input  logic             clk,
   input  logic             s_rst_n,
   input  logic [CNT_W-1:0] in_cnt,
   input  logic             in_vld,
   output logic             in_rdy,
   output logic             out_pulse,
   output logic             out_busy,
   output logic             error
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PULSE = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   // gap_cnt counts PULSE_GAP-1 down to 0; keep at least one bit when the gap is 0 or 1
   localparam int               GAP_W   = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_INI = GAP_W'((PULSE_GAP > 0) ? PULSE_GAP - 1 : 0);

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] rem, rem_nxt;       // pulses still owed after the current one
   logic [GAP_W-1:0] gap_cnt, gap_nxt;
   logic             tail, tail_nxt;     // gap after the last pulse of a command
   logic             err_nxt;
   logic             fsm_rdy;
   logic             cmd_vld;
   logic [CNT_W-1:0] cmd_cnt;
   logic             cmd_take;
   logic             pulse_q, busy_q, err_q;

   // FSM can take a command when nothing (including a trailing gap) is left to emit
   assign fsm_rdy = (state == IDLE)
                 || ((state == PULSE) && (rem == '0) && (PULSE_GAP == 0))
                 || ((state == GAP) && tail && (gap_cnt == '0));

   assign cmd_take = cmd_vld && fsm_rdy;

`ifdef COMMON_LIB_RDY_VLD_TO_PULSE_IN_PIPE_EN
   logic             stg_vld, stg_vld_nxt;
   logic [CNT_W-1:0] stg_cnt;
   logic             in_rdy_q;
   logic             fsm_rdy_nxt;
   logic             stg_load;

   assign cmd_vld  = stg_vld;
   assign cmd_cnt  = stg_cnt;
   assign in_rdy   = in_rdy_q;
   assign stg_load = in_vld && in_rdy_q;

   // stage holds a command until the FSM takes it; a new one may land in the same cycle
   assign stg_vld_nxt = (stg_vld && !fsm_rdy) || stg_load;

   // predict next-cycle FSM readiness so a full stage can still accept when it will drain
   assign fsm_rdy_nxt = (state_nxt == IDLE)
                     || ((state_nxt == PULSE) && (rem_nxt == '0) && (PULSE_GAP == 0))
                     || ((state_nxt == GAP) && tail_nxt && (gap_nxt == '0));

   // input stage valid and registered ready
   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         stg_vld  <= 1'b0;
         in_rdy_q <= 1'b1;
      end else begin
         stg_vld  <= stg_vld_nxt;
         in_rdy_q <= !stg_vld_nxt || fsm_rdy_nxt;
      end
   end

   // input stage data, captured only on transfer
   always_ff @(posedge clk) begin
      if (stg_load) begin
         stg_cnt <= in_cnt;
      end
   end
`else
   assign cmd_vld = in_vld;
   assign cmd_cnt = in_cnt;
   assign in_rdy  = fsm_rdy;
`endif

   // next-state logic; a command is only ever taken where the default next state is IDLE
   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      gap_nxt   = gap_cnt;
      tail_nxt  = tail;
      err_nxt   = 1'b0;
      case (state)
         PULSE: begin
            if (rem != '0) begin
               rem_nxt = rem - CNT_W'(1);
               if (PULSE_GAP == 0) begin
                  state_nxt = PULSE;
               end else begin
                  state_nxt = GAP;
                  gap_nxt   = GAP_INI;
                  tail_nxt  = 1'b0;
               end
            end else if (PULSE_GAP != 0) begin
               state_nxt = GAP;
               gap_nxt   = GAP_INI;
               tail_nxt  = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         GAP: begin
            if (gap_cnt != '0) begin
               gap_nxt = gap_cnt - GAP_W'(1);
            end else if (!tail) begin
               state_nxt = PULSE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (cmd_take) begin
         if (cmd_cnt != '0) begin
            state_nxt = PULSE;
            rem_nxt   = cmd_cnt - CNT_W'(1);
            tail_nxt  = 1'b0;
         end else begin
            err_nxt = 1'b1;
         end
      end
   end

   // state registers and registered outputs
   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         state   <= IDLE;
         rem     <= '0;
         gap_cnt <= '0;
         tail    <= 1'b0;
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         rem     <= rem_nxt;
         gap_cnt <= gap_nxt;
         tail    <= tail_nxt;
         pulse_q <= (state_nxt == PULSE);
         busy_q  <= (state_nxt != IDLE);
         err_q   <= err_nxt;
      end
   end

   assign out_pulse = pulse_q;
   assign out_busy  = busy_q;
   assign error     = err_q;

endmodule

// File: tb/tb_common_lib_rdy_vld_to_pulse.sv
// Bench for common_lib_rdy_vld_to_pulse: instance k runs with PULSE_GAP=k.
// Expected pulse/error cycles are pushed on accept and matched as the DUTs emit them.
// Only one instance is exercised at a time so a single ordered scoreboard suffices.

module tb_common_lib_rdy_vld_to_pulse;

   localparam int CNT_W = 8;
`ifdef COMMON_LIB_RDY_VLD_TO_PULSE_IN_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      int idx;
      int cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             s_rst_n;
   logic [CNT_W-1:0] in_cnt    [3];
   logic             in_vld    [3];
   logic             in_rdy    [3];
   logic             out_pulse [3];
   logic             out_busy  [3];
   logic             error     [3];

   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t pq[$];
   exp_t eq[$];
   int   last_exp  [3];
   int   pulse_cnt [3];
   int   last_pulse[3];

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   common_lib_rdy_vld_to_pulse #(.CNT_W(CNT_W), .PULSE_GAP(0)) u_g0 (
      .clk(clk), .s_rst_n(s_rst_n), .in_cnt(in_cnt[0]), .in_vld(in_vld[0]), .in_rdy(in_rdy[0]),
      .out_pulse(out_pulse[0]), .out_busy(out_busy[0]), .error(error[0]));
   common_lib_rdy_vld_to_pulse #(.CNT_W(CNT_W), .PULSE_GAP(1)) u_g1 (
      .clk(clk), .s_rst_n(s_rst_n), .in_cnt(in_cnt[1]), .in_vld(in_vld[1]), .in_rdy(in_rdy[1]),
      .out_pulse(out_pulse[1]), .out_busy(out_busy[1]), .error(error[1]));
   common_lib_rdy_vld_to_pulse #(.CNT_W(CNT_W), .PULSE_GAP(2)) u_g2 (
      .clk(clk), .s_rst_n(s_rst_n), .in_cnt(in_cnt[2]), .in_vld(in_vld[2]), .in_rdy(in_rdy[2]),
      .out_pulse(out_pulse[2]), .out_busy(out_busy[2]), .error(error[2]));

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
   endtask

   // scoreboard monitor: push on transfer, pop on pulse/error, flag anything overdue
   exp_t me;
   int   mt;
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (s_rst_n && in_vld[k] && in_rdy[k]) begin
            mt = cyc + LAT;
            if (last_exp[k] + k + 1 > mt) mt = last_exp[k] + k + 1;
            if (in_cnt[k] == '0) begin
               me.idx = k; me.cyc = mt;
               eq.push_back(me);
            end else begin
               for (int i = 0; i < int'(in_cnt[k]); i++) begin
                  me.idx = k; me.cyc = mt + i * (k + 1);
                  pq.push_back(me);
               end
               last_exp[k] = mt + (int'(in_cnt[k]) - 1) * (k + 1);
            end
         end
         if (out_pulse[k]) begin
            pulse_cnt[k]++;
            last_pulse[k] = cyc;
            if (pq.size() == 0) chk("pulse_unexpected", int'(out_pulse[k]), 0);
            else begin
               me = pq.pop_front();
               chk("pulse_inst", k, me.idx);
               chk("pulse_time", cyc, me.cyc);
            end
         end
         if (error[k]) begin
            if (eq.size() == 0) chk("err_unexpected", int'(error[k]), 0);
            else begin
               me = eq.pop_front();
               chk("err_inst", k, me.idx);
               chk("err_time", cyc, me.cyc);
            end
         end
      end
      while (pq.size() > 0 && pq[0].cyc <= cyc) begin
         me = pq.pop_front();
         chk("pulse_missing", int'(out_pulse[me.idx]), 1);
      end
      while (eq.size() > 0 && eq[0].cyc <= cyc) begin
         me = eq.pop_front();
         chk("err_missing", int'(error[me.idx]), 1);
      end
   end

   // drive one command and wait for its transfer; keep leaves in_vld high afterwards
   task automatic send(input int k, input int c, input bit keep, output int t);
      in_cnt[k] = CNT_W'(c);
      in_vld[k] = 1'b1;
      t = -1;
      for (int i = 0; i < 200 && t < 0; i++) begin
         @(negedge clk);
         if (in_rdy[k]) t = cyc;
      end
      if (t < 0) chk("send_timeout", int'(in_rdy[k]), 1);
      @(posedge clk); #1;
      if (!keep) in_vld[k] = 1'b0;
   endtask

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((out_busy[k] || pq.size() != 0 || eq.size() != 0) && n < 2000);
      if (n >= 2000) chk("idle_timeout", int'(out_busy[k]), 0);
   endtask

   int t, t1, t2, p0, sum, c, idle;
   bit keep;

   initial begin
      s_rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_vld[k] = 1'b0; in_cnt[k] = '0;
         last_exp[k] = -1000; pulse_cnt[k] = 0; last_pulse[k] = -1000;
      end
      repeat (3) @(posedge clk);
      #1 s_rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_pulse", int'(out_pulse[k]), 0);
         chk("rst_busy", int'(out_busy[k]), 0);
         chk("rst_err", int'(error[k]), 0);
         chk("rst_rdy", int'(in_rdy[k]), 1);
      end
      @(posedge clk); #1;

      // gap 0, three pulses
      send(0, 3, 0, t);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         chk("g0_busy", int'(out_busy[0]), int'(cyc >= t + LAT && cyc <= t + LAT + 2));
`ifndef COMMON_LIB_RDY_VLD_TO_PULSE_IN_PIPE_EN
         chk("g0_rdy", int'(in_rdy[0]), int'(!(cyc >= t + 1 && cyc <= t + 2)));
`endif
      end
      wait_idle(0);

      // gap 2, two pulses; busy covers the trailing gap
      @(posedge clk); #1;
      send(2, 2, 0, t);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk("g2_busy", int'(out_busy[2]), int'(cyc >= t + LAT && cyc <= t + LAT + 5));
`ifndef COMMON_LIB_RDY_VLD_TO_PULSE_IN_PIPE_EN
         chk("g2_rdy", int'(in_rdy[2]), int'(cyc >= t + 6));
`endif
      end
      wait_idle(2);

      // gap 1, back-to-back 2 then 1 with in_vld held: pulses T+1, T+3, T+5
      @(posedge clk); #1;
      send(1, 2, 1, t1);
      send(1, 1, 0, t2);
`ifndef COMMON_LIB_RDY_VLD_TO_PULSE_IN_PIPE_EN
      chk("b2b_accept_gap", t2 - t1, 4);
`endif
      wait_idle(1);
      chk("b2b_span", last_pulse[1] - t1, LAT + 4);

      // zero count: one-cycle error, no pulse, ready stays up
      @(posedge clk); #1;
      p0 = pulse_cnt[0];
      send(0, 0, 0, t);
      @(negedge clk);
      chk("zero_busy", int'(out_busy[0]), 0);
`ifndef COMMON_LIB_RDY_VLD_TO_PULSE_IN_PIPE_EN
      chk("zero_rdy", int'(in_rdy[0]), 1);
`endif
      wait_idle(0);
      chk("zero_pulses", pulse_cnt[0] - p0, 0);

      // maximum count
      @(posedge clk); #1;
      p0 = pulse_cnt[0];
      send(0, 255, 0, t);
      wait_idle(0);
      chk("max_count", pulse_cnt[0] - p0, 255);

      // reset after two of five pulses
      @(posedge clk); #1;
      p0 = pulse_cnt[0];
      send(0, 5, 0, t);
      repeat (LAT + 1) @(negedge clk);
      #1;
      s_rst_n = 1'b0;
      pq.delete();
      last_exp[0] = -1000;
      @(negedge clk);
      chk("mid_rst_pulse", int'(out_pulse[0]), 0);
      chk("mid_rst_busy", int'(out_busy[0]), 0);
      #1 s_rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_pulse", int'(out_pulse[0]), 0);
      chk("post_rst_busy", int'(out_busy[0]), 0);
      chk("post_rst_rdy", int'(in_rdy[0]), 1);
      repeat (10) @(negedge clk);
      chk("rst_pulse_total", pulse_cnt[0] - p0, 2);

      // random traffic per instance
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         p0 = pulse_cnt[k];
         sum = 0;
         for (int n = 0; n < 30; n++) begin
            idle = $urandom_range(0, 3);
            keep = (n != 29) && ($urandom_range(0, 1) == 1);
            if (!in_vld[k]) repeat (idle) begin @(posedge clk); #1; end
            c = $urandom_range(1, 6);
            send(k, c, keep, t);
            sum += c;
         end
         wait_idle(k);
         chk("rand_total", pulse_cnt[k] - p0, sum);
      end

      chk("sb_empty", pq.size() + eq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/common_lib_rdy_vld_to_pulse.md
Name: common_lib_rdy_vld_to_pulse

Overview:
Converts rdy/vld commands back into single-cycle pulses: the counterpart of the pulse-to-rdy/vld sampler. Each accepted command carries a pulse count N. The block emits exactly N one-cycle pulses on out_pulse, separated by PULSE_GAP idle cycles. Used to replay counted events into legacy pulse-driven logic (counters, interrupt lines, trigger inputs).

Parameters:
CNT_W, 8, width of in_cnt; max pulses per command = 2^CNT_W-1
PULSE_GAP, 0, idle cycles forced between two consecutive pulses (>=0); also enforced across command boundaries

Ports:
clk  in  1  clock
s_rst_n  in  1  reset s_rst_n, synchronous, active-low; clock clk
in_cnt  in  CNT_W  number of pulses requested by command
in_vld  in  1  command valid
in_rdy  out  1  command ready
out_pulse  out  1  registered single-cycle pulse
out_busy  out  1  1 while any pulse of accepted commands remains to be emitted (incl. gap cycles)
error  out  1  registered 1-cycle flag: command with in_cnt==0 accepted

Behaviour:
- Reset: state=IDLE, rem=0, gap_cnt=0, out_pulse=0, out_busy=0, error=0; in_rdy=1 combinationally after reset. Reset mid-operation drops all remaining pulses; no pulse in the cycle after reset deasserts.
- FSM states: IDLE, PULSE, GAP. out_pulse = (state==PULSE), driven from a flop.
- Accept: transfer on in_vld & in_rdy at cycle T. If in_cnt!=0: rem<=in_cnt-1, state<=PULSE, so first out_pulse at T+1 (latency 1). If in_cnt==0: state unchanged, error<=1 at T+1, no pulse.
- PULSE: if rem!=0: state<=(PULSE_GAP==0 ? PULSE : GAP), gap_cnt<=PULSE_GAP-1, rem<=rem-1. If rem==0 (last pulse): next command accepted this cycle -> follows accept rule; else if PULSE_GAP!=0 -> GAP with gap_cnt<=PULSE_GAP-1 and a tail flag set (the gap is still honoured before the next command); else -> IDLE.
- GAP: gap_cnt decrements each cycle. At gap_cnt==0: -> PULSE if rem pending; if tail, -> IDLE, unless a command is accepted this cycle (accept rule).
- in_rdy = IDLE, or (PULSE & rem==0 & PULSE_GAP==0), or (GAP & tail & gap_cnt==0). Back-to-back commands therefore produce uniform spacing: pulses every PULSE_GAP+1 cycles with no extra bubble.
- in_rdy does not depend on in_vld. in_cnt is sampled only on transfer.
- out_busy = (state!=IDLE).
- Max count 2^CNT_W-1 emitted exactly; no wrap of rem.

Optional Feature:
Macro COMMON_LIB_RDY_VLD_TO_PULSE_IN_PIPE_EN.
- Defined: a 1-deep registered input stage (data+valid) sits ahead of the FSM. The external in_rdy is a flop output, equal to ~stage_full | fsm_rdy registered. This breaks the in_vld->in_rdy timing path. Latency from transfer to first pulse is 2. Steady-state spacing is unchanged. error timing also shifts by +1.
- Undefined: direct path as above, latency 1.

Test Plan:
- PULSE_GAP=0, single cmd in_cnt=3 at T -> out_pulse=1 at T+1..T+3. out_busy 1 at T+1..T+3. in_rdy=1 at T+3, 0 at T+1..T+2.
- PULSE_GAP=2, cmd in_cnt=2 at T -> pulses at T+1 and T+4. out_busy 1 at T+1..T+6. in_rdy=1 at T+6.
- PULSE_GAP=1, back-to-back cmds cnt=2 then cnt=1 with in_vld held -> pulses at T+1, T+3, T+5; no extra bubble between commands.
- cmd in_cnt=0 -> error=1 for exactly one cycle at T+1. No out_pulse. in_rdy stays 1. Then cmd cnt=255 (CNT_W=8) -> exactly 255 pulses.
- s_rst_n asserted mid-command (after 2 of 5 pulses) -> out_pulse=0, out_busy=0 from the cycle after reset. No residual pulses. in_rdy=1 after reset.
- With COMMON_LIB_RDY_VLD_TO_PULSE_IN_PIPE_EN: cmd cnt=1 at T -> pulse at T+2. Random in_vld and in_cnt -> total pulses equal sum of accepted counts. Spacing is never less than PULSE_GAP+1.
